param_sequencer_core: RTL and testbench
=======================================

PARAM_SEQUENCER_CORE -- requirements
Module: param_sequencer_core

Interface
REQ-001 SHALL have parameter NUM_CH, default 16, meaning driver channel count (1..16).
REQ-002 SHALL have parameter DEPTH, default 64, meaning pattern steps per channel (power of two, 2..1024).
REQ-003 SHALL have parameter TIMER_W, default 16, meaning step-period counter width.
REQ-004 SHALL have port clock, input, 1, meaning the single clock; all logic is rising-edge.
REQ-005 SHALL have port reset_n, input, 1, meaning reset, asynchronous and active-low.
REQ-006 SHALL have port cmd_valid, input, 1, meaning a command word is present.
REQ-007 SHALL have port cmd_ready, output, 1, meaning a command is accepted this cycle.
REQ-008 SHALL have port cmd_data, input, 32, meaning the command word: [31:28] opcode, [27:16] address, [15:0] data.
REQ-009 SHALL have port control_trigger, input, 1, meaning an external start request (rising-edge detected).
REQ-010 SHALL have port driver_io, output, 2*NUM_CH, meaning per-channel pair {p,n} at bits [2i+1:2i].
REQ-011 SHALL have port update_cycle_complete, output, 1, meaning a one-cycle pulse at the end of a non-looping sequence.
REQ-012 SHALL have port busy, output, 1, meaning the state is not IDLE.
REQ-013 SHALL have port cmd_error, output, 1, meaning a one-cycle pulse when an accepted command is rejected.

Function
REQ-014 SHALL accept a command on any cycle with cmd_valid&&cmd_ready; cmd_ready SHALL be 1 whenever reset_n is high.
REQ-015 SHALL implement opcode 0x1, which writes data[NUM_CH-1:0] to enable_mem[address mod DEPTH]; this is legal in any state and takes effect on the next read of that step.
REQ-016 SHALL implement opcode 0x2, which writes data[NUM_CH-1:0] to state_mem[address mod DEPTH]; this is legal in any state.
REQ-017 SHALL implement opcode 0x3, a config write. Address 0 sets period (TIMER_W bits), 1 sets last_step, 2 sets invert_mask, 3 sets mode (bit0 loop, bit1 arm). It is accepted only in IDLE; otherwise it is ignored and cmd_error is pulsed.
REQ-018 SHALL implement opcode 0x4 (start) and opcode 0x5 (stop); any other opcode SHALL be ignored and SHALL pulse cmd_error.
REQ-019 SHALL implement FSM states IDLE, RUN, GAP and DONE.
REQ-020 SHALL move IDLE->RUN on a start command or a control_trigger rising edge when mode.arm=1, loading step=0 and timer=period-1. Start while unarmed SHALL pulse cmd_error.
REQ-021 SHALL, in RUN, decrement the timer each cycle and move RUN->GAP when the timer is 0; a period of 0 SHALL be treated as 1.
REQ-022 SHALL hold GAP for exactly one cycle (dead-time) with all driver_io pairs at 2'b00.
REQ-023 SHALL, on leaving GAP, go to RUN with step+1 when step<last_step. At step==last_step it SHALL wrap to step 0 in RUN if loop=1, else go to DONE.
REQ-024 SHALL hold DONE for one cycle, pulse update_cycle_complete, then return to IDLE.
REQ-025 SHALL clamp a last_step value >= DEPTH to DEPTH-1 at the write.
REQ-026 SHALL force a stop command in any state to IDLE on the next cycle, with outputs 2'b00 and no update_cycle_complete.
REQ-027 SHALL give stop priority over a simultaneous start or trigger; start or trigger while not IDLE SHALL be ignored.
REQ-028 SHALL register the per-channel output in RUN: enable_mem[step][i]=0 gives 2'b00; otherwise d=state_mem[step][i]^invert_mask[i], and d=1 gives 2'b10 while d=0 gives 2'b01.
REQ-029 SHALL make driver_io reflect a new step one cycle after the step register updates.
REQ-030 SHALL never drive 2'b11 on driver_io in any state.
REQ-031 SHALL detect control_trigger edges using one registered sample of the previous value; no synchroniser is required (input is clock-synchronous).

Reset
REQ-032 SHALL, on reset_n low, immediately set the following, independent of clock: state=IDLE, driver_io=0, update_cycle_complete=0, cmd_error=0, busy=0, step=0, timer=0, period=1, last_step=0, invert_mask=0, mode=0, trigger history=0.
REQ-033 SHALL leave pattern memory contents undefined after reset; the bench SHALL write every step used before starting.
REQ-034 SHALL, on reset asserted mid-RUN, force outputs to 0 within the same cycle; after release the block SHALL be in IDLE.

Verification
REQ-035 Scenario: NUM_CH=16, period=3, last_step=1, loop=0, arm=1, enable={FFFF,FFFF}, state={AAAA,5555}, start -> ch0 reads 01 for 3 cycles, 00 for 1 cycle, then 10 for 3 cycles, followed by GAP, a DONE pulse and busy low.
REQ-036 Scenario: same setup with invert_mask=0001 -> ch0 polarity swapped on both steps; all other channels unchanged.
REQ-037 Scenario: loop=1 with last_step=2 -> step sequence 0,1,2,0,1 with no update_cycle_complete; stop mid-RUN -> driver_io=0 next cycle and busy=0.
REQ-038 Scenario: config write (opcode 3) during RUN -> cmd_error pulse and period unchanged; opcode 0xF in IDLE -> cmd_error pulse.
REQ-039 Scenario: trigger rising edge and stop in the same cycle from IDLE -> remains IDLE; last_step written as 2000 with DEPTH=64 -> reads back as effective 63 (sequence runs 64 steps).
REQ-040 Scenario: reset_n pulsed low mid-step -> driver_io=0 asynchronously; then start with period=0 -> each step lasts 1 cycle plus 1 GAP cycle.

Source files
------------

// File: rtl/param_sequencer_core_if.sv
// Command bus of the pattern sequencer.
//   cmd_valid : a command word is present
//   cmd_ready : the sequencer accepts the word this cycle
//   cmd_data  : [31:28] opcode, [27:16] address, [15:0] data
// master modport drives commands, slave modport is the sequencer side.
interface param_sequencer_core_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_data;

  modport master (output cmd_valid, output cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_data, output cmd_ready);
endinterface

// File: rtl/param_sequencer_core.sv
// Per-channel driver pattern sequencer.
// Steps through DEPTH-entry enable/state pattern memories, holding each step for
// `period` cycles followed by a one-cycle all-off dead-time, optionally looping.
// Ports:
//   clock, reset_n        : rising-edge clock, asynchronous active-low reset
//   cmd                   : command bus (slave modport), always ready out of reset
//   control_trigger       : synchronous start request, rising-edge detected
//   driver_io             : {p,n} pair per channel at [2i+1:2i], registered
//   update_cycle_complete : one-cycle pulse while in DONE of a non-looping run
//   busy                  : sequencer not idle
//   cmd_error             : one-cycle pulse after a rejected command
module param_sequencer_core #(
  parameter int unsigned NUM_CH  = 16,
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned TIMER_W = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  param_sequencer_core_if.slave cmd,
  input  logic                  control_trigger,
  output logic [2*NUM_CH-1:0]   driver_io,
  output logic                  update_cycle_complete,
  output logic                  busy,
  output logic                  cmd_error
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [3:0] OP_EN    = 4'h1;
  localparam logic [3:0] OP_ST    = 4'h2;
  localparam logic [3:0] OP_CFG   = 4'h3;
  localparam logic [3:0] OP_START = 4'h4;
  localparam logic [3:0] OP_STOP  = 4'h5;

  typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} state_e;

  logic [NUM_CH-1:0]   enable_mem [DEPTH];
  logic [NUM_CH-1:0]   state_mem  [DEPTH];

  state_e              state_q;
  logic [AW-1:0]       step_q;
  logic [AW-1:0]       last_step_q;
  logic [TIMER_W-1:0]  timer_q;
  logic [TIMER_W-1:0]  period_q;
  logic [NUM_CH-1:0]   invert_q;
  logic [1:0]          mode_q;     // bit0 loop, bit1 arm
  logic                trig_q;
  logic [2*NUM_CH-1:0] driver_q;
  logic [2*NUM_CH-1:0] driver_d;
  logic                ucc_q;
  logic                err_q;

  logic                accept;
  logic [3:0]          opcode;
  logic [11:0]         cfg_addr;
  logic [AW-1:0]       mem_addr;
  logic [15:0]         data;
  logic                is_start;
  logic                is_stop;
  logic                trig_edge;
  logic [TIMER_W-1:0]  timer_reload;
  logic [AW-1:0]       last_step_wr;
  logic                unused_cmd_bits;

  assign cmd.cmd_ready = reset_n;
  assign accept        = cmd.cmd_valid & cmd.cmd_ready;
  assign opcode        = cmd.cmd_data[31:28];
  assign cfg_addr      = cmd.cmd_data[27:16];
  assign mem_addr      = cmd.cmd_data[16 +: AW];
  assign data          = cmd.cmd_data[15:0];
  assign is_start      = accept && (opcode == OP_START);
  assign is_stop       = accept && (opcode == OP_STOP);
  assign trig_edge     = control_trigger & ~trig_q;
  assign unused_cmd_bits = ^cmd.cmd_data;

  // A zero period behaves as a one-cycle step.
  assign timer_reload = (period_q == '0) ? '0 : period_q - TIMER_W'(1);
  assign last_step_wr = (32'(data) >= DEPTH) ? AW'(DEPTH - 1) : data[AW-1:0];

  // Pattern memories are not reset; writes are legal in every state.
  always_ff @(posedge clock) begin
    if (accept && (opcode == OP_EN)) enable_mem[mem_addr] <= data[NUM_CH-1:0];
    if (accept && (opcode == OP_ST)) state_mem[mem_addr]  <= data[NUM_CH-1:0];
  end

  // Outputs track the state/step of the previous cycle, so a new step shows up
  // one cycle after the step register moves and GAP/DONE show all-off pairs.
  always_comb begin
    driver_d = '0;
    if (state_q == RUN) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (enable_mem[step_q][i])
          driver_d[2*i +: 2] = (state_mem[step_q][i] ^ invert_q[i]) ? 2'b10 : 2'b01;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      step_q      <= '0;
      last_step_q <= '0;
      timer_q     <= '0;
      period_q    <= TIMER_W'(1);
      invert_q    <= '0;
      mode_q      <= '0;
      trig_q      <= 1'b0;
      driver_q    <= '0;
      ucc_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      trig_q   <= control_trigger;
      driver_q <= driver_d;
      ucc_q    <= 1'b0;
      err_q    <= 1'b0;

      if (accept) begin
        case (opcode)
          OP_CFG: begin
            if (state_q == IDLE) begin
              case (cfg_addr)
                12'd0:   period_q    <= TIMER_W'(data);
                12'd1:   last_step_q <= last_step_wr;
                12'd2:   invert_q    <= data[NUM_CH-1:0];
                12'd3:   mode_q      <= data[1:0];
                default: ;
              endcase
            end else begin
              err_q <= 1'b1;
            end
          end
          OP_START: if ((state_q == IDLE) && !mode_q[1]) err_q <= 1'b1;
          OP_EN, OP_ST, OP_STOP: ;
          default: err_q <= 1'b1;
        endcase
      end

      // Stop wins over everything, including a start or trigger in the same cycle.
      if (is_stop) begin
        state_q  <= IDLE;
        driver_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (mode_q[1] && (is_start || trig_edge)) begin
              state_q <= RUN;
              step_q  <= '0;
              timer_q <= timer_reload;
            end
          end
          RUN: begin
            if (timer_q == '0) state_q <= GAP;
            else               timer_q <= timer_q - TIMER_W'(1);
          end
          GAP: begin
            if (step_q < last_step_q) begin
              state_q <= RUN;
              step_q  <= step_q + AW'(1);
              timer_q <= timer_reload;
            end else if (mode_q[0]) begin
              state_q <= RUN;
              step_q  <= '0;
              timer_q <= timer_reload;
            end else begin
              state_q <= DONE;
              ucc_q   <= 1'b1;
            end
          end
          DONE:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign driver_io             = driver_q;
  assign update_cycle_complete = ucc_q;
  assign busy                  = (state_q != IDLE);
  assign cmd_error             = err_q;

endmodule

// File: tb/tb_param_sequencer_core.sv
// Self-checking bench for param_sequencer_core (NUM_CH=16, DEPTH=64).
// A trace model expands each run into the list of phases it must pass through
// and predicts outputs per cycle; directed scenarios add literal expectations.
module tb_param_sequencer_core;
  localparam int NUM_CH  = 16;
  localparam int DEPTH   = 64;
  localparam int TIMER_W = 16;

  localparam int IDLEP = -3;
  localparam int DONEP = -2;
  localparam int GAPP  = -1;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        control_trigger = 1'b0;
  logic [31:0] driver_io;
  logic        update_cycle_complete;
  logic        busy;
  logic        cmd_error;

  param_sequencer_core_if cmd_bus ();

  param_sequencer_core #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .TIMER_W(TIMER_W)) dut (
    .clock                 (clock),
    .reset_n               (reset_n),
    .cmd                   (cmd_bus),
    .control_trigger       (control_trigger),
    .driver_io             (driver_io),
    .update_cycle_complete (update_cycle_complete),
    .busy                  (busy),
    .cmd_error             (cmd_error)
  );

  always #5 clock = ~clock;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- trace model ----------------
  logic [15:0] m_en [DEPTH];
  logic [15:0] m_st [DEPTH];
  logic [15:0] m_inv;
  int          m_period, m_last;
  logic        m_loop, m_arm, m_trig;
  int          cur_phase;
  int          ph_q[$];
  logic [31:0] e_drv;
  logic        e_busy, e_ucc, e_err;

  function automatic logic [31:0] pat(input int s);
    logic [31:0] w = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (m_en[s][i] === 1'b1) w[2*i +: 2] = (m_st[s][i] ^ m_inv[i]) ? 2'b10 : 2'b01;
    return w;
  endfunction

  // A run is: for each step, `period` cycles showing that step then one dead cycle;
  // non-looping runs end with a single DONE cycle. Loops are expanded 6 times.
  task automatic build_run();
    int p = (m_period == 0) ? 1 : m_period;
    int iters = m_loop ? 6 : 1;
    ph_q.delete();
    for (int it = 0; it < iters; it++)
      for (int s = 0; s <= m_last; s++) begin
        for (int k = 0; k < p; k++) ph_q.push_back(s);
        ph_q.push_back(GAPP);
      end
    if (!m_loop) ph_q.push_back(DONEP);
  endtask

  task automatic model_edge();
    logic [3:0]  op   = cmd_bus.cmd_data[31:28];
    int          a    = int'(cmd_bus.cmd_data[27:16]);
    logic [15:0] d    = cmd_bus.cmd_data[15:0];
    logic        acc  = cmd_bus.cmd_valid;
    logic        idle = (cur_phase == IDLEP);
    logic        tedge = control_trigger && !m_trig;
    logic        err = 1'b0, go = 1'b0, stop = 1'b0;
    logic [31:0] nd;
    m_trig = control_trigger;
    nd = (cur_phase >= 0) ? pat(cur_phase) : '0;
    if (acc) begin
      case (op)
        4'h1, 4'h2: ;
        4'h3: if (!idle) err = 1'b1;
        4'h4: if (idle) begin if (m_arm) go = 1'b1; else err = 1'b1; end
        4'h5: stop = 1'b1;
        default: err = 1'b1;
      endcase
    end
    if (idle && m_arm && tedge) go = 1'b1;
    if (stop) begin
      ph_q.delete();
      cur_phase = IDLEP;
      nd = '0;
    end else if (go) begin
      build_run();
      cur_phase = ph_q.pop_front();
    end else if (!idle) begin
      if (ph_q.size() > 0) cur_phase = ph_q.pop_front();
      else                 cur_phase = IDLEP;
    end
    if (acc && op == 4'h1) m_en[a % DEPTH] = d;
    if (acc && op == 4'h2) m_st[a % DEPTH] = d;
    if (acc && op == 4'h3 && idle) begin
      case (a)
        0: m_period = int'(d);
        1: m_last = (int'(d) >= DEPTH) ? DEPTH - 1 : int'(d);
        2: m_inv = d;
        3: begin m_loop = d[0]; m_arm = d[1]; end
        default: ;
      endcase
    end
    e_drv  = nd;
    e_busy = (cur_phase != IDLEP);
    e_ucc  = (cur_phase == DONEP);
    e_err  = err;
  endtask

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cur_phase = IDLEP;
      ph_q.delete();
      m_inv = '0; m_period = 1; m_last = 0; m_loop = 1'b0; m_arm = 1'b0; m_trig = 1'b0;
      e_drv = '0; e_busy = 1'b0; e_ucc = 1'b0; e_err = 1'b0;
    end else begin
      model_edge();
    end
  end

  always @(negedge clock) begin
    if (reset_n === 1'b1) begin
      check("drv", driver_io, e_drv);
      check("busy", 32'(busy), 32'(e_busy));
      check("ucc", 32'(update_cycle_complete), 32'(e_ucc));
      check("err", 32'(cmd_error), 32'(e_err));
      check("ready", 32'(cmd_bus.cmd_ready), 32'd1);
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] cap_drv  [32];
  logic        cap_busy [32];
  logic        cap_ucc  [32];

  task automatic send(input logic [3:0] op, input int addr, input logic [15:0] d);
    cmd_bus.cmd_valid = 1'b1;
    cmd_bus.cmd_data  = {op, 12'(addr), d};
    @(posedge clock); #1;
    cmd_bus.cmd_valid = 1'b0;
    cmd_bus.cmd_data  = '0;
  endtask

  task automatic cfg(input int a, input logic [15:0] d);
    send(4'h3, a, d);
  endtask

  task automatic capture(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      cap_drv[k] = driver_io; cap_busy[k] = busy; cap_ucc[k] = update_cycle_complete;
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin @(negedge clock); n++; end
    check("idle_reached", 32'(busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_ch0 [10] = '{0, 1, 1, 1, 0, 2, 2, 2, 0, 0};
    int nb, nu;
    cmd_bus.cmd_valid = 1'b0;
    cmd_bus.cmd_data  = '0;
    #12;
    check("rst_drv", driver_io, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ucc", 32'(update_cycle_complete), 32'd0);
    check("rst_err", 32'(cmd_error), 32'd0);
    @(posedge clock); #1; reset_n = 1'b1;
    @(posedge clock); #1;

    // Two-step single run, period 3
    send(4'h1, 0, 16'hFFFF); send(4'h1, 1, 16'hFFFF);
    send(4'h2, 0, 16'hAAAA); send(4'h2, 1, 16'h5555);
    cfg(0, 16'd3); cfg(1, 16'd1); cfg(3, 16'h2);
    send(4'h4, 0, 16'h0);
    capture(10);
    for (int k = 0; k < 10; k++)
      check($sformatf("s1_ch0_%0d", k), 32'(cap_drv[k][1:0]), 32'(exp_ch0[k]));
    check("s1_step0", cap_drv[1], 32'h9999_9999);
    check("s1_step1", cap_drv[5], 32'h6666_6666);
    check("s1_ucc_pre", 32'(cap_ucc[7]), 32'd0);
    check("s1_ucc", 32'(cap_ucc[8]), 32'd1);
    check("s1_busy_done", 32'(cap_busy[8]), 32'd1);
    check("s1_busy_end", 32'(cap_busy[9]), 32'd0);
    wait_idle(50);

    // Channel 0 inverted
    cfg(2, 16'h0001);
    send(4'h4, 0, 16'h0);
    capture(10);
    check("s2_step0", cap_drv[1], 32'h9999_999A);
    check("s2_step1", cap_drv[5], 32'h6666_6665);
    wait_idle(50);
    cfg(2, 16'h0000);

    // Looping three-step run, stopped mid-RUN
    send(4'h1, 2, 16'h00FF); send(4'h2, 2, 16'h0000);
    cfg(0, 16'd2); cfg(1, 16'd2); cfg(3, 16'h3);
    send(4'h4, 0, 16'h0);
    capture(14);
    check("s3_s0", cap_drv[1],  32'h9999_9999);
    check("s3_s1", cap_drv[4],  32'h6666_6666);
    check("s3_s2", cap_drv[7],  32'h0000_5555);
    check("s3_s0b", cap_drv[10], 32'h9999_9999);
    check("s3_s1b", cap_drv[13], 32'h6666_6666);
    nu = 0;
    for (int k = 0; k < 14; k++) if (cap_ucc[k]) nu++;
    check("s3_no_ucc", 32'(nu), 32'd0);
    send(4'h5, 0, 16'h0);
    @(negedge clock);
    check("s3_stop_drv", driver_io, 32'd0);
    check("s3_stop_busy", 32'(busy), 32'd0);

    // Config during RUN rejected, period kept
    cfg(0, 16'd3); cfg(1, 16'd1); cfg(3, 16'h2);
    send(4'h4, 0, 16'h0);
    @(negedge clock);
    send(4'h3, 0, 16'd7);
    @(negedge clock);
    check("s4_cfg_err", 32'(cmd_error), 32'd1);
    wait_idle(50);
    send(4'h4, 0, 16'h0);
    capture(10);
    check("s4_len_busy", 32'(cap_busy[8]), 32'd1);
    check("s4_len_end", 32'(cap_busy[9]), 32'd0);
    wait_idle(50);
    send(4'hF, 0, 16'h0);
    @(negedge clock);
    check("s4_badop_err", 32'(cmd_error), 32'd1);
    cfg(3, 16'h0);
    send(4'h4, 0, 16'h0);
    @(negedge clock);
    check("s4_unarmed_err", 32'(cmd_error), 32'd1);
    check("s4_unarmed_busy", 32'(busy), 32'd0);

    // Trigger with stop stays idle; trigger alone starts
    cfg(3, 16'h2);
    control_trigger = 1'b1;
    send(4'h5, 0, 16'h0);
    @(negedge clock);
    check("s5_trig_stop", 32'(busy), 32'd0);
    control_trigger = 1'b0;
    @(posedge clock); #1;
    control_trigger = 1'b1;
    @(posedge clock); #1;
    control_trigger = 1'b0;
    @(negedge clock);
    check("s5_trig_start", 32'(busy), 32'd1);
    wait_idle(50);

    // last_step clamp: 64 steps of period 1
    for (int s = 0; s < DEPTH; s++) begin
      send(4'h1, s, 16'hFFFF);
      send(4'h2, s, 16'(s * 16'h0407));
    end
    cfg(0, 16'd1); cfg(1, 16'd2000); cfg(3, 16'h2);
    send(4'h4, 0, 16'h0);
    nb = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clock);
      if (busy !== 1'b1) break;
      nb++;
    end
    check("s5_clamp_len", 32'(nb), 32'd129);

    // Asynchronous reset mid-step, then period 0
    send(4'h2, 0, 16'hAAAA); send(4'h2, 1, 16'h5555);
    cfg(0, 16'd4); cfg(1, 16'd1);
    send(4'h4, 0, 16'h0);
    repeat (3) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("s6_async_drv", driver_io, 32'd0);
    check("s6_async_busy", 32'(busy), 32'd0);
    @(posedge clock); #1; reset_n = 1'b1;
    @(posedge clock); #1;
    send(4'h1, 0, 16'hFFFF); send(4'h1, 1, 16'hFFFF);
    send(4'h2, 0, 16'hAAAA); send(4'h2, 1, 16'h5555);
    cfg(0, 16'd0); cfg(1, 16'd1); cfg(3, 16'h2);
    send(4'h4, 0, 16'h0);
    capture(6);
    check("s6_idx0", cap_drv[0], 32'd0);
    check("s6_idx1", cap_drv[1], 32'h9999_9999);
    check("s6_idx2", cap_drv[2], 32'd0);
    check("s6_idx3", cap_drv[3], 32'h6666_6666);
    check("s6_ucc", 32'(cap_ucc[4]), 32'd1);
    check("s6_end", 32'(cap_busy[5]), 32'd0);
    wait_idle(50);

    repeat (3) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
